// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// fq_entry_t is one fetch-queue slot: the PC a word was fetched from plus the
// instruction word itself. It is sized by PC_W_DEF/INS_W_DEF, so the fetch
// unit must be built with matching PC_W/INS_W.
package fetch_pkg;

  localparam int PC_W_DEF   = 9;
  localparam int INS_W_DEF  = 32;
  localparam int FETCH_STEP = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [INS_W_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between instruction memory and decode.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (control state only)
//   flush        synchronous clear; wins over push/pop in the same cycle
//   push         write push_entry at the tail (caller guarantees room)
//   push_entry   entry to write
//   pop          remove the head; ignored while empty
//   head         current head entry (contents undefined while empty)
//   empty        no entries held
//   count        number of occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fq_entry_t                push_entry,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t        store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop & ~empty;
  assign head   = store[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end for the 5-stage RV32 pipeline.
// Issues pipelined requests to instruction memory under a credit scheme
// (every outstanding request owns a queue slot), buffers returned words in a
// fetch queue, and presents {pc, instr} to decode. A redirect from EX flushes
// the queue and discards every response still in flight; halt_req stops new
// requests until the next redirect or reset.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   imem_req_valid/addr/ready          fetch request handshake
//   imem_rsp_valid/data                in-order response words
//   redirect_valid/redirect_pc         flush + new fetch target
//   halt_req                           stop issuing requests (sticky)
//   id_valid/id_pc/id_instr/id_ready   decode handshake (head of queue)
//   fq_count                           fetch queue occupancy
//   halted                             fetch is stopped by halt_req
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          PC_W        = 9,
  parameter int          INS_W       = 32,
  parameter int          FETCH_DEPTH = 4,
  parameter int          MAX_OUT     = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           imem_req_valid,
  output logic [PC_W-1:0]                imem_req_addr,
  input  logic                           imem_req_ready,
  input  logic                           imem_rsp_valid,
  input  logic [INS_W-1:0]               imem_rsp_data,
  input  logic                           redirect_valid,
  input  logic [PC_W-1:0]                redirect_pc,
  input  logic                           halt_req,
  output logic                           id_valid,
  output logic [PC_W-1:0]                id_pc,
  output logic [INS_W-1:0]               id_instr,
  input  logic                           id_ready,
  output logic [$clog2(FETCH_DEPTH):0]   fq_count,
  output logic                           halted
);

  localparam int OW = $clog2(MAX_OUT) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;
  logic [31:0]     occupancy;
  logic            can_issue;
  logic            accept;
  logic            push;
  logic            pop;
  logic            q_empty;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  function automatic logic [PC_W-1:0] pc_step(input logic [PC_W-1:0] pc);
    return pc + PC_W'(FETCH_STEP);
  endfunction

  // Queued words plus words still in flight may never exceed the queue, so
  // every response is guaranteed a slot and memory is never backpressured.
  assign occupancy      = 32'(fq_count) + 32'(outstanding);
  assign can_issue      = (outstanding < OW'(MAX_OUT)) && (occupancy < 32'(FETCH_DEPTH));
  assign imem_req_valid = ~reset & ~halted & ~redirect_valid & can_issue;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // Wrong-path words (counted in discard) and words landing in a redirect
  // cycle are dropped instead of queued.
  assign push             = imem_rsp_valid & ~redirect_valid & (discard == '0);
  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;

  assign id_valid = ~q_empty;
  assign pop      = id_valid & id_ready;
  assign id_pc    = id_valid ? head.pc    : '0;
  assign id_instr = id_valid ? head.instr : '0;

  fetch_queue #(
    .DEPTH(FETCH_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (q_empty),
    .count     (fq_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= PC_W'(RESET_PC);
      rsp_pc      <= PC_W'(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
    end else begin
      unique case ({accept, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (redirect_valid) begin
        // Everything still in flight after this cycle is wrong-path; that
        // count already includes any earlier discards not yet drained.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        halted   <= 1'b0;
        discard  <= outstanding - OW'(imem_rsp_valid);
      end else begin
        if (accept) fetch_pc <= pc_step(fetch_pc);
        if (imem_rsp_valid) begin
          if (discard != '0) discard <= discard - 1'b1;
          else               rsp_pc  <= pc_step(rsp_pc);
        end
        if (halt_req) halted <= 1'b1;
      end
    end
  end

  rsp_has_owner: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              imem_req_valid;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_req_ready = 1'b0;
  logic              imem_rsp_valid = 1'b0;
  logic [INS_W-1:0]  imem_rsp_data = '0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              halt_req = 1'b0;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INS_W-1:0]  id_instr;
  logic              id_ready = 1'b0;
  logic [2:0]        fq_count;
  logic              halted;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .PC_W(PC_W), .INS_W(INS_W), .FETCH_DEPTH(DEPTH), .MAX_OUT(MAXO), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .fq_count(fq_count), .halted(halted)
  );

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
    bit              stale;
  } mreq_t;

  mreq_t           memq[$];
  logic [PC_W-1:0] sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int tickno = 0;
  int lat = 1;
  int pops = 0;
  int first_pc = -1;
  int wrap_watch = 0;
  bit rdy_rand = 0;
  bit collide_arm = 0;
  logic [PC_W-1:0] collide_pc = '0;
  logic [PC_W-1:0] exp_addr = '0;
  logic            nx_id_ready = 1'b1;
  bit              nx_redir = 0;
  logic [PC_W-1:0] nx_redir_pc = '0;
  bit              nx_halt = 0;

  function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // One clock cycle: apply stimulus and memory outputs at the falling edge,
  // then score the decode handshake and record accepted requests.
  task automatic tick();
    mreq_t           cur;
    bit              have;
    int              inflight;
    logic [PC_W-1:0] want;
    @(negedge clk);
    tickno++;
    id_ready       = nx_id_ready;
    redirect_valid = nx_redir;
    redirect_pc    = nx_redir_pc;
    halt_req       = nx_halt;
    nx_redir = 0;
    nx_halt  = 0;
    inflight = memq.size();
    have = 0;
    if (memq.size() > 0 && memq[0].due <= tickno) begin
      cur  = memq.pop_front();
      have = 1;
    end
    imem_rsp_valid = have;
    imem_rsp_data  = have ? instr_of(cur.addr) : '0;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    if (collide_arm && have && imem_req_valid && !redirect_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = collide_pc;
      collide_arm    = 0;
      #1;
      chk("collide_noreq", 32'(imem_req_valid), 0);
    end
    if (imem_req_valid) begin
      chk("credit_out", 32'(inflight < MAXO), 1);
      chk("credit_q", 32'((int'(fq_count) + inflight) < DEPTH), 1);
    end
    if (redirect_valid) chk("redir_noreq", 32'(imem_req_valid), 0);
    if (halted)         chk("halt_noreq", 32'(imem_req_valid), 0);
    if (id_valid && id_ready) begin
      pops++;
      if (sb.size() == 0) chk("sb_empty_pop", 1, 0);
      else begin
        want = sb.pop_front();
        chk("id_pc", 32'(id_pc), 32'(want));
        chk("id_instr", id_instr, instr_of(want));
      end
      if (first_pc >= 0) begin
        chk("first_pc", 32'(id_pc), 32'(first_pc));
        first_pc = -1;
      end
    end
    if (redirect_valid) begin
      sb.delete();
      foreach (memq[i]) memq[i].stale = 1;
      exp_addr = redirect_pc;
      first_pc = int'(redirect_pc);
    end else if (have && !cur.stale) begin
      sb.push_back(cur.addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", 32'(imem_req_addr), 32'(exp_addr));
      if (wrap_watch == 2) begin
        chk("wrap_to_zero", 32'(imem_req_addr), 0);
        wrap_watch = 0;
      end else if (wrap_watch == 1 && imem_req_addr == 9'h1FC) begin
        wrap_watch = 2;
      end
      memq.push_back('{addr: imem_req_addr, due: tickno + lat, stale: 1'b0});
      exp_addr = exp_addr + 9'd4;
    end
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset          = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_fq_count", 32'(fq_count), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_id_pc", 32'(id_pc), 0);
    chk("rst_id_instr", id_instr, 0);
    memq.delete();
    sb.delete();
    exp_addr    = '0;
    first_pc    = 0;
    wrap_watch  = 0;
    collide_arm = 0;
    nx_redir    = 0;
    nx_halt     = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_first(input string tag);
    for (int i = 0; i < 40 && first_pc >= 0; i++) tick();
    if (first_pc >= 0) begin
      chk(tag, 0, 1);
      first_pc = -1;
    end
  endtask

  initial begin
    logic [PC_W-1:0]  hold_pc;
    logic [INS_W-1:0] hold_ins;
    int p0;

    do_reset();

    // Zero-wait memory, decode always ready: one instruction per cycle.
    lat = 1;
    nx_id_ready = 1'b1;
    repeat (6) tick();
    p0 = pops;
    repeat (10) begin
      tick();
      chk("fq_le2", 32'(fq_count <= 3'd2), 1);
    end
    chk("throughput", 32'(pops - p0), 10);

    // Decode stall: queue fills to capacity, head held stable.
    nx_id_ready = 1'b0;
    tick();
    hold_pc  = id_pc;
    hold_ins = id_instr;
    repeat (9) begin
      tick();
      chk("hold_pc", 32'(id_pc), 32'(hold_pc));
      chk("hold_instr", id_instr, hold_ins);
    end
    chk("stall_full", 32'(fq_count), 4);
    chk("stall_noreq", 32'(imem_req_valid), 0);
    chk("stall_mem_idle", 32'(memq.size()), 0);
    lat = 3;
    nx_id_ready = 1'b1;

    // Redirect with two requests in flight at latency 3.
    for (int i = 0; i < 30 && memq.size() != 2; i++) tick();
    chk("two_inflight", 32'(memq.size()), 2);
    nx_redir = 1;
    nx_redir_pc = 9'h040;
    tick();
    wait_first("redir40_timeout");
    repeat (4) tick();

    // Redirect landing on a response and a request attempt together.
    collide_pc  = 9'h080;
    collide_arm = 1;
    for (int i = 0; i < 40 && collide_arm; i++) tick();
    if (collide_arm) begin
      chk("collide_timeout", 0, 1);
      collide_arm = 0;
    end
    wait_first("redir80_timeout");

    // Halt with two outstanding: both words still delivered, no new requests.
    for (int i = 0; i < 40 && !(memq.size() == 2 && !memq[0].stale && !memq[1].stale); i++) tick();
    chk("halt_two_inflight", 32'(memq.size()), 2);
    nx_halt = 1;
    tick();
    tick();
    chk("halted_set", 32'(halted), 1);
    repeat (12) tick();
    chk("halt_sb_drained", 32'(sb.size()), 0);
    chk("halt_mem_drained", 32'(memq.size()), 0);
    chk("halt_q_empty", 32'(fq_count), 0);
    chk("halt_sticky", 32'(halted), 1);
    nx_redir = 1;
    nx_redir_pc = 9'h010;
    tick();
    tick();
    chk("halt_cleared", 32'(halted), 0);
    wait_first("redir10_timeout");

    // Random memory readiness and decode stalls.
    lat = 2;
    rdy_rand = 1;
    repeat (40) begin
      nx_id_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    rdy_rand = 0;
    nx_id_ready = 1'b1;
    repeat (8) tick();

    // PC wrap at the top of the 9-bit space, then reset mid-burst.
    lat = 1;
    nx_redir = 1;
    nx_redir_pc = 9'h1F8;
    wrap_watch = 1;
    tick();
    for (int i = 0; i < 30 && wrap_watch != 0; i++) tick();
    if (wrap_watch != 0) begin
      chk("wrap_timeout", 0, 1);
      wrap_watch = 0;
    end
    tick();
    chk("burst_inflight", 32'(memq.size() > 0), 1);
    do_reset();
    wait_first("restart_timeout");

    // Final drain.
    nx_halt = 1;
    repeat (15) tick();
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
